// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU operand/operation selects and the packed control-word layout.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       iord;
    logic       alu_src_a;
    logic       pc_src;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle of controller <-> datapath/memory signals; the controller drives
// enables/selects, the datapath side drives opcode and status strobes.
interface multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        iord;
  logic        alu_src_a;
  logic        pc_src;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        illegal;

  modport ctrl (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
           iord, alu_src_a, pc_src, alu_src_b, alu_op, state, retired, illegal
  );

  modport dp (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
           iord, alu_src_a, pc_src, alu_src_b, alu_op, state, retired, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Five-state multicycle RISC-V style controller with a retired-instruction
// counter and a sticky illegal-opcode flag.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        iord,
  output logic        alu_src_a,
  output logic        pc_src,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        retire;
  ctrl_t       ctl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // opcode is only consulted outside FETCH; the IR is still being loaded there
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_legal(opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) begin
          state_d = S_MEM;
        end else if (opcode == OP_BRANCH) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (opcode == OP_R || opcode == OP_I) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + 32'd1 : retired_q;
  end

  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALUOP_ADD;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        case (opcode)
          OP_R:      begin ctl.alu_src_b = SRCB_REG; ctl.alu_op = ALUOP_FUNCT; end
          OP_I:      begin ctl.alu_src_b = SRCB_IMM; ctl.alu_op = ALUOP_FUNCT; end
          OP_LOAD,
          OP_STORE:  begin ctl.alu_src_b = SRCB_IMM; ctl.alu_op = ALUOP_ADD;   end
          OP_BRANCH: begin
            ctl.alu_src_b = SRCB_REG;
            ctl.alu_op    = ALUOP_SUB;
            ctl.pc_src    = 1'b1;
            ctl.pc_write  = zero;
          end
          default: ctl.alu_src_a = 1'b1;
        endcase
      end
      S_MEM: begin
        ctl.iord      = 1'b1;
        ctl.mem_read  = (opcode == OP_LOAD);
        ctl.mem_write = (opcode != OP_LOAD);
      end
      S_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = (opcode == OP_LOAD);
      end
      default: ctl = '0;
    endcase
    // reset may land mid-wait; keep every architectural write off meanwhile
    if (rst) begin
      ctl.pc_write  = 1'b0;
      ctl.ir_write  = 1'b0;
      ctl.reg_write = 1'b0;
      ctl.mem_write = 1'b0;
    end
  end

  assign pc_write   = ctl.pc_write;
  assign ir_write   = ctl.ir_write;
  assign reg_write  = ctl.reg_write;
  assign mem_read   = ctl.mem_read;
  assign mem_write  = ctl.mem_write;
  assign mem_to_reg = ctl.mem_to_reg;
  assign iord       = ctl.iord;
  assign alu_src_a  = ctl.alu_src_a;
  assign pc_src     = ctl.pc_src;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;
  assign state      = state_q;
  assign retired    = retired_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: each instruction expands into per-cycle stimulus plus the
// expected state and control word, which are popped and compared cycle by cycle.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (bus.opcode),
    .zero       (bus.zero),
    .mem_ready  (bus.mem_ready),
    .pc_write   (bus.pc_write),
    .ir_write   (bus.ir_write),
    .reg_write  (bus.reg_write),
    .mem_read   (bus.mem_read),
    .mem_write  (bus.mem_write),
    .mem_to_reg (bus.mem_to_reg),
    .iord       (bus.iord),
    .alu_src_a  (bus.alu_src_a),
    .pc_src     (bus.pc_src),
    .alu_src_b  (bus.alu_src_b),
    .alu_op     (bus.alu_op),
    .state      (bus.state),
    .retired    (bus.retired),
    .illegal    (bus.illegal)
  );

  typedef struct {
    logic        ready;
    logic [6:0]  op;
    logic        z;
    logic [2:0]  st;
    logic [12:0] ctl;
  } cyc_t;

  cyc_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_retired;
  logic        exp_illegal;

  localparam logic [6:0] JUNK = 7'b1111111;

  // {pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, iord,
  //  alu_src_a, pc_src, alu_src_b, alu_op}
  function automatic logic [12:0] mk(input logic pcw, irw, rw, mr, mw, m2r, io, sa, ps,
                                     input logic [1:0] sb, aop);
    return {pcw, irw, rw, mr, mw, m2r, io, sa, ps, sb, aop};
  endfunction

  function automatic logic [12:0] obs();
    return {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write,
            bus.mem_to_reg, bus.iord, bus.alu_src_a, bus.pc_src, bus.alu_src_b, bus.alu_op};
  endfunction

  function automatic cyc_t cy(input logic r, input logic [6:0] op, input logic z,
                              input logic [2:0] st, input logic [12:0] c);
    cyc_t t;
    t.ready = r; t.op = op; t.z = z; t.st = st; t.ctl = c;
    return t;
  endfunction

  task automatic build(input logic [6:0] op, input logic z, input int fwait, input int mwait);
    for (int i = 0; i < fwait; i++)
      q.push_back(cy(1'b0, JUNK, z, 3'd0, mk(0,0,0,1,0,0,0,0,0,2'b01,2'b00)));
    q.push_back(cy(1'b1, JUNK, z, 3'd0, mk(1,1,0,1,0,0,0,0,0,2'b01,2'b00)));
    q.push_back(cy(1'b0, op, z, 3'd1, mk(0,0,0,0,0,0,0,0,0,2'b10,2'b00)));
    case (op)
      7'b0110011, 7'b0010011: begin
        q.push_back(cy(1'b0, op, z, 3'd2,
          mk(0,0,0,0,0,0,0,1,0,(op == 7'b0110011) ? 2'b00 : 2'b10,2'b10)));
        q.push_back(cy(1'b0, op, z, 3'd4, mk(0,0,1,0,0,0,0,0,0,2'b00,2'b00)));
        exp_retired = exp_retired + 32'd1;
      end
      7'b0000011, 7'b0100011: begin
        logic ld;
        ld = (op == 7'b0000011);
        q.push_back(cy(1'b0, op, z, 3'd2, mk(0,0,0,0,0,0,0,1,0,2'b10,2'b00)));
        for (int i = 0; i <= mwait; i++)
          q.push_back(cy(i == mwait, op, z, 3'd3, mk(0,0,0,ld,!ld,0,1,0,0,2'b00,2'b00)));
        if (ld) q.push_back(cy(1'b0, op, z, 3'd4, mk(0,0,1,0,0,1,0,0,0,2'b00,2'b00)));
        exp_retired = exp_retired + 32'd1;
      end
      7'b1100011: begin
        q.push_back(cy(1'b0, op, z, 3'd2, mk(z,0,0,0,0,0,0,1,1,2'b00,2'b01)));
        exp_retired = exp_retired + 32'd1;
      end
      default: exp_illegal = 1'b1;
    endcase
  endtask

  task automatic play(input string name);
    cyc_t c;
    int n;
    n = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      bus.mem_ready = c.ready; bus.opcode = c.op; bus.zero = c.z;
      #1;
      total++;
      if (bus.state !== c.st) begin
        bad++; $display("FAIL %s cyc%0d state: got %0d want %0d", name, n, bus.state, c.st);
      end
      total++;
      if (obs() !== c.ctl) begin
        bad++; $display("FAIL %s cyc%0d ctl: got %b want %b", name, n, obs(), c.ctl);
      end
      n++;
    end
  endtask

  task automatic check_end(input string name);
    @(posedge clk); #1;
    total++;
    if (bus.state !== 3'd0) begin
      bad++; $display("FAIL %s end state: got %0d want 0", name, bus.state);
    end
    total++;
    if (bus.retired !== exp_retired) begin
      bad++; $display("FAIL %s retired: got %0h want %0h", name, bus.retired, exp_retired);
    end
    total++;
    if (bus.illegal !== exp_illegal) begin
      bad++; $display("FAIL %s illegal: got %b want %b", name, bus.illegal, exp_illegal);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 7'b0110011; bus.zero = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({bus.state, bus.retired, bus.illegal} !== 36'd0) begin
      bad++; $display("FAIL reset regs: got st=%0d ret=%0h ill=%b want 0", bus.state, bus.retired, bus.illegal);
    end
    total++;
    if ({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write} !== 4'b0) begin
      bad++; $display("FAIL reset enables: got %b want 0000",
        {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write});
    end
    rst = 1'b0; bus.mem_ready = 1'b0;
    exp_retired = '0; exp_illegal = 1'b0;
  endtask

  task automatic test_alu();
    build(7'b0110011, 1'b0, 0, 0); play("add"); check_end("add");
    build(7'b0010011, 1'b1, 1, 0); play("addi"); check_end("addi");
  endtask

  task automatic test_load_wait();
    build(7'b0000011, 1'b0, 0, 3); play("lw_wait"); check_end("lw_wait");
  endtask

  task automatic test_branch();
    build(7'b1100011, 1'b1, 0, 0); play("beq_taken"); check_end("beq_taken");
    build(7'b1100011, 1'b0, 0, 0); play("beq_not"); check_end("beq_not");
  endtask

  task automatic test_illegal();
    build(JUNK, 1'b0, 0, 0); play("illegal"); check_end("illegal");
    build(7'b0100011, 1'b0, 2, 1); play("sw_after_ill"); check_end("sw_after_ill");
  endtask

  task automatic test_back_to_back();
    build(7'b0100011, 1'b0, 0, 0);
    build(7'b0000011, 1'b0, 0, 0);
    build(7'b1100011, 1'b1, 0, 0);
    build(7'b0110011, 1'b0, 0, 0);
    play("b2b"); check_end("b2b");
  endtask

  task automatic test_reset_in_mem();
    build(7'b0100011, 1'b0, 0, 2);
    void'(q.pop_back());
    play("sw_rst");
    @(negedge clk);
    rst = 1'b1; bus.mem_ready = 1'b0;
    #1;
    total++;
    if ({bus.mem_write, bus.pc_write, bus.reg_write, bus.ir_write} !== 4'b0) begin
      bad++; $display("FAIL rst_in_mem enables: got %b want 0000",
        {bus.mem_write, bus.pc_write, bus.reg_write, bus.ir_write});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_retired = '0; exp_illegal = 1'b0;
    total++;
    if ({bus.state, bus.retired, bus.illegal, bus.mem_write} !== 37'd0) begin
      bad++; $display("FAIL rst_in_mem after: got st=%0d ret=%0h ill=%b mw=%b want 0",
        bus.state, bus.retired, bus.illegal, bus.mem_write);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    exp_retired = 32'hFFFF_FFFF;
    build(7'b0100011, 1'b0, 0, 0); play("wrap"); check_end("wrap");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_reset_in_mem();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port opcode  input  7  instruction[6:0], taken from the instruction register.
REQ-004 SHALL have port zero  input  1  ALU zero flag.
REQ-005 SHALL have port mem_ready  input  1  unified-memory completion strobe for the current access.
REQ-006 SHALL have outputs pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, iord, alu_src_a, pc_src, each 1 bit, as named datapath enables and selects.
REQ-007 SHALL have outputs alu_src_b (2 bits: 00 reg B, 01 constant 4, 10 immediate) and alu_op (2 bits: 00 add, 01 sub, 10 funct-decoded).
REQ-008 SHALL have outputs state (3 bits, current FSM state), retired (32 bits, retired-instruction count) and illegal (1 bit, sticky illegal-opcode flag).

Function
REQ-009 SHALL implement states FETCH, DECODE, EXEC, MEM and WB.
REQ-010 FETCH SHALL assert mem_read=1, iord=0, alu_src_a=0, alu_src_b=01 and alu_op=00.
REQ-011 FETCH SHALL assert ir_write and pc_write (pc_src=0) only in the cycle mem_ready=1, then go to DECODE; otherwise it SHALL hold FETCH.
REQ-012 DECODE SHALL assert alu_src_a=0, alu_src_b=10 and alu_op=00 to precompute the branch target.
REQ-013 DECODE SHALL go to EXEC for opcodes 0110011, 0010011, 0000011, 0100011 and 1100011.
REQ-014 DECODE SHALL, for any other opcode, set illegal and return to FETCH without incrementing retired.
REQ-015 EXEC for R-type (0110011) SHALL assert alu_src_a=1, alu_src_b=00, alu_op=10, then go to WB.
REQ-016 EXEC for I-ALU (0010011) SHALL assert alu_src_a=1, alu_src_b=10, alu_op=10, then go to WB.
REQ-017 EXEC for load/store SHALL assert alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM.
REQ-018 EXEC for branch SHALL assert alu_src_a=1, alu_src_b=00, alu_op=01 and pc_src=1, with pc_write=zero.
REQ-019 EXEC for branch SHALL then go to FETCH and increment retired.
REQ-020 MEM SHALL assert iord=1 together with mem_read=1 (load) or mem_write=1 (store).
REQ-021 MEM SHALL hold while mem_ready=0.
REQ-022 MEM on mem_ready=1 SHALL go to WB for a load, or to FETCH with retired incremented for a store.
REQ-023 WB SHALL assert reg_write=1 and mem_to_reg=1 (load) or 0 (R/I-ALU), then go to FETCH and increment retired.
REQ-024 Every enable and select not listed for a state SHALL be 0 in that state.
REQ-025 Outputs SHALL be Moore functions of state, except ir_write/pc_write in FETCH (mem_ready) and pc_write in EXEC (zero).
REQ-026 retired SHALL increment by exactly 1 per completed instruction and wrap from 0xFFFFFFFF to 0.
REQ-027 Instruction latencies with mem_ready=1 SHALL be: branch 3, R/I-ALU 4, store 4, load 5 cycles; each wait cycle SHALL add 1.
REQ-028 opcode SHALL be sampled only in DECODE, EXEC, MEM and WB; changes while in FETCH SHALL be ignored.
REQ-029 illegal, once set, SHALL remain 1 until reset.

Reset
REQ-030 When rst=1 at a clock edge, the FSM SHALL enter FETCH and set retired=0 and illegal=0, regardless of the current state or any pending memory wait.
REQ-031 While rst=1, pc_write, ir_write, reg_write and mem_write SHALL be 0.

Structure
REQ-032 State encodings (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4), opcode constants and the alu_op/alu_src_b encodings SHALL live in a shared package, ctrl_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the retired counter SHALL be inline.

Verification
REQ-034 Reset, then add (0110011) with mem_ready=1 -> state sequence 0,1,2,4,0; reg_write=1 only in WB; retired=1.
REQ-035 lw (0000011) with mem_ready low 3 cycles in MEM -> MEM held 3 extra cycles; total 8 cycles; mem_to_reg=1 in WB.
REQ-036 beq with zero=1, then with zero=0 -> pc_write=1 and pc_src=1 in EXEC only for the first; 3 cycles each; retired=2.
REQ-037 opcode 1111111 -> DECODE returns to FETCH; illegal=1 and stays 1; retired unchanged.
REQ-038 rst asserted during MEM wait of a store -> next state FETCH, mem_write=0, retired=0.
REQ-039 Preload retired=0xFFFFFFFF via force, retire one store -> retired=0.
